// File: rtl/ir_cmd_controller.sv
// IR command controller: sequences the decoder, validates 32-bit NEC-style
// frames, expands repeat bursts and queues commands in a small output FIFO.
module ir_cmd_controller #(
    parameter int unsigned FRAME_TIMEOUT = 2000000,
    parameter int unsigned REPEAT_WINDOW = 6000000,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        dec_enable,
    input  logic        dec_start,
    input  logic        dec_repeat,
    input  logic        dec_frame_done,
    input  logic [31:0] dec_command,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [16:0] out_data,
    output logic [7:0]  err_count,
    output logic        overflow
);

    localparam int unsigned FTW = $clog2(FRAME_TIMEOUT + 1);
    localparam int unsigned RTW = $clog2(REPEAT_WINDOW + 1);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = AW + 1;

    typedef enum logic [1:0] {IDLE, LISTEN, RECEIVE, CHECK} state_t;

    state_t          state, next_state;
    logic [FTW-1:0]  frame_timer;
    logic [31:0]     frame_q;
    logic [RTW-1:0]  repeat_timer;
    logic            repeat_armed;
    logic [7:0]      last_addr, last_cmd;
    logic [16:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    logic            frame_clr, frame_inc, capture, push_req, err_inc;
    logic            arm_set, arm_clr, rep_clr;
    logic [16:0]     push_data;
    logic            frame_expired, frame_ok, fifo_full, pop, do_push;

    assign frame_expired = (frame_timer == FTW'(FRAME_TIMEOUT - 1));
    assign frame_ok      = (frame_q[15:8] == ~frame_q[7:0]) &&
                           (frame_q[31:24] == ~frame_q[23:16]);
    assign fifo_full     = (count == CW'(FIFO_DEPTH));
    assign pop           = out_valid && out_ready;
    assign do_push       = push_req && (!fifo_full || pop);
    assign out_valid     = (count != '0);
    assign out_data      = mem[rd_ptr];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next-state logic; run=0 always wins
    always_comb begin
        next_state = state;
        if (!run) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    next_state = LISTEN;
                LISTEN:  if (dec_start) next_state = RECEIVE;
                RECEIVE: begin
                    if (dec_frame_done)                   next_state = CHECK;
                    else if (!dec_start && frame_expired) next_state = LISTEN;
                end
                CHECK:   next_state = LISTEN;
                default: next_state = IDLE;
            endcase
        end
    end

    // Per-state control strobes for the datapath
    always_comb begin
        frame_clr = 1'b0;
        frame_inc = 1'b0;
        capture   = 1'b0;
        push_req  = 1'b0;
        push_data = '0;
        err_inc   = 1'b0;
        arm_set   = 1'b0;
        arm_clr   = !run;
        rep_clr   = 1'b0;
        if (run) begin
            case (state)
                LISTEN: begin
                    if (dec_start) begin
                        frame_clr = 1'b1;
                    end else if (dec_repeat && repeat_armed) begin
                        push_req  = 1'b1;
                        push_data = {1'b1, last_cmd, last_addr};
                        rep_clr   = 1'b1;
                    end
                end
                RECEIVE: begin
                    if (dec_frame_done)     capture   = 1'b1;
                    else if (dec_start)     frame_clr = 1'b1;
                    else if (frame_expired) err_inc   = 1'b1;
                    else                    frame_inc = 1'b1;
                end
                CHECK: begin
                    if (frame_ok) begin
                        push_req  = 1'b1;
                        push_data = {1'b0, frame_q[23:16], frame_q[7:0]};
                        arm_set   = 1'b1;
                    end else begin
                        err_inc   = 1'b1;
                        arm_clr   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Decoder gate follows the state being entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dec_enable <= 1'b0;
        else      dec_enable <= (next_state == LISTEN) || (next_state == RECEIVE);
    end

    // Frame timer and captured frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_timer <= '0;
            frame_q     <= '0;
        end else begin
            if (frame_clr)      frame_timer <= '0;
            else if (frame_inc) frame_timer <= frame_timer + FTW'(1);
            if (capture)        frame_q     <= dec_command;
        end
    end

    // Repeat window tracking and last accepted command
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            repeat_timer <= '0;
            repeat_armed <= 1'b0;
            last_addr    <= '0;
            last_cmd     <= '0;
        end else begin
            if (arm_clr) begin
                repeat_timer <= '0;
                repeat_armed <= 1'b0;
            end else if (arm_set || rep_clr) begin
                repeat_timer <= '0;
                repeat_armed <= 1'b1;
            end else if (repeat_armed) begin
                if (repeat_timer == RTW'(REPEAT_WINDOW - 1)) begin
                    repeat_timer <= RTW'(REPEAT_WINDOW);
                    repeat_armed <= 1'b0;
                end else begin
                    repeat_timer <= repeat_timer + RTW'(1);
                end
            end
            if (arm_set) begin
                last_addr <= frame_q[7:0];
                last_cmd  <= frame_q[23:16];
            end
        end
    end

    // Saturating error counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                            err_count <= '0;
        else if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end

    // FIFO storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (push_req && fifo_full && !pop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ir_cmd_controller.sv
// Bench for ir_cmd_controller: event-scheduled model plus directed literal checks.
module tb_ir_cmd_controller;

    localparam int unsigned FT    = 200;
    localparam int unsigned RW    = 1500;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        dec_start = 1'b0;
    logic        dec_repeat = 1'b0;
    logic        dec_frame_done = 1'b0;
    logic [31:0] dec_command = '0;
    logic        out_ready = 1'b0;
    logic        dec_enable, out_valid, overflow;
    logic [16:0] out_data;
    logic [7:0]  err_count;

    ir_cmd_controller #(
        .FRAME_TIMEOUT(FT),
        .REPEAT_WINDOW(RW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .dec_enable(dec_enable),
        .dec_start(dec_start),
        .dec_repeat(dec_repeat),
        .dec_frame_done(dec_frame_done),
        .dec_command(dec_command),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .err_count(err_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Model: expected FIFO contents, counters and future events keyed by edge index
    typedef struct {
        int          due;
        bit          is_push;
        logic [16:0] data;
    } ev_t;

    logic [16:0] mq[$];
    ev_t         evq[$];
    ev_t         keep[$];
    int          m_err = 0;
    bit          m_ovf = 1'b0;
    int          edge_no = 0;
    bit          armed = 1'b0;
    int          deadline = 0;
    logic [7:0]  l_addr = '0, l_cmd = '0;
    bit          m_pop;
    int          n_chk = 0, n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void add_ev(input int due, input bit is_push, input logic [16:0] data);
        ev_t e;
        e.due = due;
        e.is_push = is_push;
        e.data = data;
        evq.push_back(e);
    endfunction

    function automatic void model_reset();
        mq.delete();
        evq.delete();
        m_err = 0;
        m_ovf = 1'b0;
        armed = 1'b0;
    endfunction

    // Model advance on each rising edge: consumer pop first, then scheduled events
    always @(posedge clk) begin
        if (rst) begin
            m_pop = (mq.size() != 0) && out_ready;
            if (m_pop) mq.delete(0);
            keep.delete();
            foreach (evq[i]) begin
                if (evq[i].due == edge_no) begin
                    if (evq[i].is_push) begin
                        if (mq.size() < int'(DEPTH)) mq.push_back(evq[i].data);
                        else                         m_ovf = 1'b1;
                    end else if (m_err < 255) begin
                        m_err++;
                    end
                end else begin
                    keep.push_back(evq[i]);
                end
            end
            evq = keep;
        end
        edge_no++;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst) begin
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
            chk("err_count", 32'(err_count), 32'(m_err));
            chk("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    function automatic bit is_valid(input logic [31:0] c);
        return ((c[7:0] ^ c[15:8]) == 8'hFF) && ((c[23:16] ^ c[31:24]) == 8'hFF);
    endfunction

    function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
        return {~c, c, ~a, a};
    endfunction

    // Outcome of a completed frame lands one edge after the edge sampling frame_done
    function automatic void sched_done(input logic [31:0] c);
        if (is_valid(c)) begin
            add_ev(edge_no + 1, 1'b1, {1'b0, c[23:16], c[7:0]});
            armed    = 1'b1;
            deadline = edge_no + 1 + int'(RW);
            l_addr   = c[7:0];
            l_cmd    = c[23:16];
        end else begin
            add_ev(edge_no + 1, 1'b0, '0);
            armed = 1'b0;
        end
    endfunction

    // Start burst, gap cycles later frame_done; optional repeat pulse mid-frame
    task automatic frame(input logic [31:0] c, input int gap, input int rep_at);
        dec_start = 1'b1;
        tick(1);
        dec_start = 1'b0;
        for (int k = 1; k < gap; k++) begin
            dec_repeat = (k == rep_at);
            tick(1);
        end
        dec_repeat     = 1'b0;
        dec_command    = c;
        dec_frame_done = 1'b1;
        sched_done(c);
        tick(1);
        dec_frame_done = 1'b0;
    endtask

    task automatic rep();
        dec_repeat = 1'b1;
        if (armed && edge_no <= deadline) begin
            add_ev(edge_no, 1'b1, {1'b1, l_cmd, l_addr});
            deadline = edge_no + int'(RW);
        end
        tick(1);
        dec_repeat = 1'b0;
    endtask

    task automatic tmo();
        dec_start = 1'b1;
        add_ev(edge_no + int'(FT), 1'b0, '0);
        tick(1);
        dec_start = 1'b0;
        tick(int'(FT) + 1);
    endtask

    logic [16:0] drain_exp [4];

    initial begin
        drain_exp = '{17'h03111, 17'h03212, 17'h03313, 17'h03414};
        model_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data", 32'(out_data), 32'd0);
        chk("rst err_count", 32'(err_count), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        chk("rst dec_enable", 32'(dec_enable), 32'd0);
        tick(3);
        rst = 1'b1;
        tick(2);
        chk("idle dec_enable", 32'(dec_enable), 32'd0);
        run = 1'b1;
        tick(2);
        chk("listen dec_enable", 32'(dec_enable), 32'd1);

        // Basic valid frame and latency
        frame(32'hF708FB04, 100, 0);
        chk("check dec_enable", 32'(dec_enable), 32'd0);
        chk("latency1 out_valid", 32'(out_valid), 32'd0);
        tick(1);
        chk("latency2 out_valid", 32'(out_valid), 32'd1);
        chk("first out_data", 32'(out_data), 32'h00804);
        chk("first err", 32'(err_count), 32'd0);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("popped out_valid", 32'(out_valid), 32'd0);

        // Address check failure
        frame(32'hF708FB05, 5, 0);
        tick(1);
        chk("bad err", 32'(err_count), 32'd1);
        chk("bad out_valid", 32'(out_valid), 32'd0);
        chk("bad dec_enable", 32'(dec_enable), 32'd1);

        // Repeats inside and outside the window; repeat during RECEIVE ignored
        out_ready = 1'b1;
        frame(mk(8'h04, 8'h08), 10, 0);
        tick(1);
        tick(997);
        rep();
        chk("repeat out_valid", 32'(out_valid), 32'd1);
        chk("repeat out_data", 32'(out_data), 32'h10804);
        tick(1);
        frame(mk(8'h21, 8'h42), 20, 7);
        tick(1);
        chk("rx-repeat out_data", 32'(out_data), 32'h04221);
        tick(10);
        rep();
        chk("repeat2 out_data", 32'(out_data), 32'h14221);
        tick(int'(RW) + 50);
        rep();
        chk("late repeat out_valid", 32'(out_valid), 32'd0);
        chk("late repeat err", 32'(err_count), 32'd1);

        // FIFO fill, simultaneous push/pop when full, then overflow and drain
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            frame(mk(8'(8'h10 + i), 8'(8'h30 + i)), 3, 0);
            tick(1);
        end
        chk("full head", 32'(out_data), 32'h03010);
        chk("full ovf", 32'(overflow), 32'd0);
        frame(mk(8'h14, 8'h34), 3, 0);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("pushpop ovf", 32'(overflow), 32'd0);
        chk("pushpop head", 32'(out_data), 32'h03111);
        frame(mk(8'h15, 8'h35), 3, 0);
        tick(1);
        chk("overflow set", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("drain order", 32'(out_data), 32'(drain_exp[i]));
            out_ready = 1'b1;
            tick(1);
            out_ready = 1'b0;
        end
        chk("drained out_valid", 32'(out_valid), 32'd0);

        // Frame timeout, then restart that avoids a timeout
        tmo();
        chk("timeout err", 32'(err_count), 32'd2);
        chk("timeout dec_enable", 32'(dec_enable), 32'd1);
        dec_start = 1'b1;
        tick(1);
        dec_start = 1'b0;
        tick(int'(FT) - 20);
        dec_start = 1'b1;
        tick(1);
        dec_start = 1'b0;
        tick(int'(FT) - 20);
        dec_command    = mk(8'h66, 8'h99);
        dec_frame_done = 1'b1;
        sched_done(mk(8'h66, 8'h99));
        tick(1);
        dec_frame_done = 1'b0;
        tick(1);
        chk("restart err", 32'(err_count), 32'd2);
        chk("restart out_data", 32'(out_data), 32'h09966);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            frame(32'hF708FB05, 1, 0);
            tick(1);
        end
        chk("err saturate", 32'(err_count), 32'd255);

        // run=0 mid-frame abandons it and disarms repeat
        frame(mk(8'h01, 8'h02), 4, 0);
        tick(1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        dec_start = 1'b1;
        tick(1);
        dec_start = 1'b0;
        tick(5);
        run   = 1'b0;
        armed = 1'b0;
        tick(1);
        chk("run0 dec_enable", 32'(dec_enable), 32'd0);
        tick(3);
        run = 1'b1;
        tick(2);
        chk("rerun dec_enable", 32'(dec_enable), 32'd1);
        rep();
        chk("disarmed out_valid", 32'(out_valid), 32'd0);
        chk("run0 err", 32'(err_count), 32'd255);

        // Reset during RECEIVE, then a normal frame
        dec_start = 1'b1;
        tick(1);
        dec_start = 1'b0;
        tick(10);
        rst = 1'b0;
        model_reset();
        #1;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst out_data", 32'(out_data), 32'd0);
        chk("midrst err", 32'(err_count), 32'd0);
        chk("midrst ovf", 32'(overflow), 32'd0);
        chk("midrst dec_enable", 32'(dec_enable), 32'd0);
        tick(2);
        rst = 1'b1;
        tick(2);
        frame(mk(8'h5A, 8'hC3), 30, 0);
        tick(1);
        chk("post-rst out_data", 32'(out_data), 32'h0C35A);
        chk("post-rst err", 32'(err_count), 32'd0);
        out_ready = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
